// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one operand bit pair per cycle to an external
// 1-bit full-adder cell and assembles the sum LSB first in a right-shifting register.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             w_accept;
  logic             w_step;
  logic             w_last;

  assign w_accept = (r_state == S_IDLE) && start;
  // An abort edge cancels the step entirely, so cout and carry stay untouched.
  assign w_step   = (r_state == S_RUN) && !abort;
  assign w_last   = (r_cnt == LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_RUN;
      S_RUN: begin
        if (abort)       w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a_in;
      r_b     <= b_in;
      r_carry <= cin;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else if (w_step) begin
      r_sum   <= {fa_s, r_sum[WIDTH-1:1]};
      r_carry <= fa_co;
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) r_cout <= fa_co;
    end
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign fa_a  = busy & r_a[0];
  assign fa_b  = busy & r_b[0];
  assign fa_ci = busy & r_carry;
  assign sum   = r_sum;
  assign cout  = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a behavioural full-adder cell and
// an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         fa_a, fa_b, fa_ci, fa_s, fa_co;
  logic         ready, busy, done, cout;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 ck = ~ck;

  // External full-adder cell
  assign fa_s  = fa_a ^ fa_b ^ fa_ci;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .ck(ck), .rst(rst), .start(start), .abort(abort),
    .a_in(a_in), .b_in(b_in), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci), .fa_s(fa_s), .fa_co(fa_co),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    longint t;
    t = longint'(a) + longint'(b) + longint'(c);
    return t[W:0];
  endfunction

  // Carry into bit i is bit i of the sum of the operands' low i bits plus cin.
  function automatic logic [W-1:0] ref_trace(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W-1:0] tr;
    longint mask, t;
    for (int i = 0; i < W; i++) begin
      mask = (longint'(1) << i) - 1;
      t = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
      tr[i] = t[i];
    end
    return tr;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic ab,
                        output logic [W-1:0] s, output logic co, output int nb,
                        output logic [W-1:0] tr, output logic seen);
    @(negedge ck);
    a_in = a; b_in = b; cin = c; start = 1'b1; abort = ab;
    @(negedge ck);
    start = 1'b0; abort = 1'b0;
    nb = 0; tr = '0; seen = 1'b0;
    for (int k = 0; k < 4*W; k++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) begin
        if (nb < W) tr[nb] = fa_ci;
        nb++;
      end
      @(negedge ck);
    end
    s = sum; co = cout;
    $display("op a=%h b=%h cin=%0d -> sum=%h cout=%0d busy_cycles=%0d done=%0d", a, b, c, s, co, nb, seen);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge ck);
    @(negedge ck);
    n_checks++; if ({ready, busy, done} !== 3'b100) $display("FAIL reset_flags: got %b expected 100", {ready, busy, done}); else n_pass++;
    n_checks++; if ({sum, cout} !== '0) $display("FAIL reset_result: got sum=%h cout=%0d expected 0/0", sum, cout); else n_pass++;
    n_checks++; if ({fa_a, fa_b, fa_ci} !== 3'b000) $display("FAIL reset_fa: got %b expected 000", {fa_a, fa_b, fa_ci}); else n_pass++;
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_directed;
    logic [W-1:0] va[3] = '{8'hFF, 8'h5A, 8'h5A};
    logic [W-1:0] vb[3] = '{8'h01, 8'hA5, 8'hA5};
    logic         vc[3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] s, tr;
    logic         co, seen;
    int           nb;
    logic [W:0]   exp;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, s, co, nb, tr, seen);
      exp = ref_add(va[i], vb[i], vc[i]);
      n_checks++; if (!seen) $display("FAIL dir_done: got no done expected done"); else n_pass++;
      n_checks++; if ({co, s} !== exp) $display("FAIL dir_result: got %h expected %h", {co, s}, exp); else n_pass++;
      n_checks++; if (nb !== W) $display("FAIL dir_latency: got %0d busy cycles expected %0d", nb, W); else n_pass++;
      n_checks++; if (tr !== ref_trace(va[i], vb[i], vc[i])) $display("FAIL dir_fa_ci_trace: got %b expected %b", tr, ref_trace(va[i], vb[i], vc[i])); else n_pass++;
      @(negedge ck);
      n_checks++; if ({ready, done} !== 2'b10) $display("FAIL dir_done_pulse: got ready/done=%b expected 10", {ready, done}); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, s, tr;
    logic         c, co, seen;
    int           nb;
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      run_op(a, b, c, 1'b0, s, co, nb, tr, seen);
      n_checks++; if (!seen || {co, s} !== ref_add(a, b, c)) $display("FAIL rand_result: got %h done=%0d expected %h", {co, s}, seen, ref_add(a, b, c)); else n_pass++;
      n_checks++; if (nb !== W || tr !== ref_trace(a, b, c)) $display("FAIL rand_trace: got n=%0d tr=%b expected n=%0d tr=%b", nb, tr, W, ref_trace(a, b, c)); else n_pass++;
    end
  endtask

  task automatic test_start_ignored;
    int nb, extra_done, extra_busy;
    logic seen;
    @(negedge ck);
    a_in = 8'h3C; b_in = 8'h47; cin = 1'b1; start = 1'b1;
    @(negedge ck);
    start = 1'b0; nb = 0; seen = 1'b0;
    for (int k = 0; k < 4*W; k++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) begin
        if (nb == 3) begin start = 1'b1; a_in = 8'h99; b_in = 8'h11; cin = 1'b0; end
        else start = 1'b0;
        nb++;
      end
      @(negedge ck);
    end
    start = 1'b0;
    $display("op a=3c b=47 cin=1 with mid-run start -> sum=%h cout=%0d", sum, cout);
    n_checks++; if (!seen || {cout, sum} !== ref_add(8'h3C, 8'h47, 1'b1)) $display("FAIL ignore_result: got %h expected %h", {cout, sum}, ref_add(8'h3C, 8'h47, 1'b1)); else n_pass++;
    extra_done = 0; extra_busy = 0;
    for (int k = 0; k < 2*W; k++) begin
      @(negedge ck);
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    n_checks++; if (extra_done + extra_busy !== 0) $display("FAIL ignore_no_second: got done=%0d busy=%0d expected 0/0", extra_done, extra_busy); else n_pass++;
  endtask

  task automatic test_abort;
    logic [W-1:0] s, tr, a, b;
    logic         co, seen, c;
    int           nb, nd;
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, s, co, nb, tr, seen);
    @(negedge ck);
    a_in = 8'h00; b_in = 8'h00; cin = 1'b0; start = 1'b1;
    @(negedge ck);
    start = 1'b0; nb = 0;
    for (int k = 0; k < 2*W && nb <= 4; k++) begin
      if (busy) begin
        if (nb == 4) abort = 1'b1;
        nb++;
      end
      @(negedge ck);
    end
    abort = 1'b0;
    $display("abort at run cycle 4 -> ready=%0d busy=%0d cout=%0d", ready, busy, cout);
    n_checks++; if ({ready, busy, done} !== 3'b100) $display("FAIL abort_state: got %b expected 100", {ready, busy, done}); else n_pass++;
    n_checks++; if (cout !== 1'b1) $display("FAIL abort_cout: got %0d expected 1", cout); else n_pass++;
    nd = 0;
    for (int k = 0; k < W+2; k++) begin @(negedge ck); if (done) nd++; end
    n_checks++; if (nd !== 0) $display("FAIL abort_no_done: got %0d pulses expected 0", nd); else n_pass++;
    a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    run_op(a, b, c, 1'b1, s, co, nb, tr, seen);
    n_checks++; if (!seen || {co, s} !== ref_add(a, b, c)) $display("FAIL abort_start_together: got %h done=%0d expected %h", {co, s}, seen, ref_add(a, b, c)); else n_pass++;
  endtask

  task automatic test_reset_midrun;
    logic [W-1:0] s, tr;
    logic         co, seen;
    int           nb;
    @(negedge ck);
    a_in = 8'hF0; b_in = 8'h1F; cin = 1'b1; start = 1'b1;
    @(negedge ck);
    start = 1'b0; nb = 0;
    for (int k = 0; k < 2*W && nb <= 5; k++) begin
      if (busy) begin
        if (nb == 5) rst = 1'b1;
        nb++;
      end
      @(negedge ck);
    end
    $display("reset at run cycle 5 -> ready=%0d sum=%h cout=%0d", ready, sum, cout);
    n_checks++; if ({ready, busy, done} !== 3'b100) $display("FAIL midrst_flags: got %b expected 100", {ready, busy, done}); else n_pass++;
    n_checks++; if ({sum, cout, fa_a, fa_b, fa_ci} !== '0) $display("FAIL midrst_regs: got sum=%h cout=%0d fa=%b expected all 0", sum, cout, {fa_a, fa_b, fa_ci}); else n_pass++;
    rst = 1'b0;
    run_op(8'h12, 8'h34, 1'b0, 1'b0, s, co, nb, tr, seen);
    n_checks++; if (!seen || {co, s} !== 9'h046) $display("FAIL midrst_after: got %h expected 046", {co, s}); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [W:0] exp_q[$];
    logic [W:0] exp;
    int cyc, last_done, nres;
    cyc = 0; last_done = -1; nres = 0;
    @(negedge ck);
    a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom); start = 1'b1;
    for (int k = 0; k < 200 && nres < 5; k++) begin
      if (done) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        $display("b2b result %0d: sum=%h cout=%0d", nres, sum, cout);
        n_checks++; if ({cout, sum} !== exp) $display("FAIL b2b_result: got %h expected %h", {cout, sum}, exp); else n_pass++;
        if (last_done >= 0) begin
          n_checks++; if (cyc - last_done !== W + 2) $display("FAIL b2b_period: got %0d expected %0d", cyc - last_done, W + 2); else n_pass++;
        end
        last_done = cyc;
        nres++;
      end
      if (nres < 5) begin
        if (ready) exp_q.push_back(ref_add(a_in, b_in, cin));
        else if (busy) begin a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom); end
        @(negedge ck);
        cyc++;
      end
    end
    start = 1'b0;
    n_checks++; if (nres !== 5) $display("FAIL b2b_timeout: got %0d results expected 5", nres); else n_pass++;
    repeat (2) @(negedge ck);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
